// File: rtl/std_arb_pkg.sv
// Shared types and limits for the std_mem_d1 round-robin arbiter.
//   arb_state_e : arbiter FSM states
//   ARB_MAX_REQ : largest supported requester count
package std_arb_pkg;

    localparam int ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/std_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : highest-priority index; the search wraps cyclically from here
//   winner : one-hot first set bit at or after ptr (0 if none)
//   any    : at least one request is set
module std_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);

    logic found;

    // Walk priority slots k = 0..N-1; slot k maps to index (ptr+k) mod N.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] &&
                    ((int'(ptr) + k == i) || (int'(ptr) + k == i + N))) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        any = |req;
    end

endmodule

// File: rtl/std_mem_d1_arb.sv
// Round-robin arbiter sharing one std_mem_d1 port among NUM_REQ requesters.
// One access in flight at a time; go/done handshake per requester.
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/write_en     : per-requester request and direction (1 = write)
//   req_addr/write_data    : packed per-requester operands, slice i = requester i
//   req_done               : one-cycle pulse to the served requester
//   req_read_data          : last completed read result (shared)
//   grant                  : one-hot current owner, 0 when idle
//   mem_*                  : memory port (combinational read, registered write done)
module std_mem_d1_arb
    import std_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4,
    parameter int NUM_REQ  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write_en,
    input  logic [NUM_REQ*IDX_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]    req_write_data,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [WIDTH-1:0]            req_read_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic [IDX_SIZE-1:0]         mem_addr0,
    output logic [WIDTH-1:0]            mem_write_data,
    output logic                        mem_write_en,
    input  logic [WIDTH-1:0]            mem_read_data,
    input  logic                        mem_done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
        $error("std_mem_d1_arb: NUM_REQ must be in 2..%0d", ARB_MAX_REQ);
    end

    arb_state_e          state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  winner;
    logic                any;
    logic [IDX_SIZE-1:0] sel_addr;
    logic [WIDTH-1:0]    sel_wdata;
    logic                sel_we;
    logic [PW-1:0]       sel_idx;
    logic [PW-1:0]       next_ptr;

    std_rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    // Operand mux driven by the latched one-hot grant.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_addr  = req_addr[i*IDX_SIZE +: IDX_SIZE];
                sel_wdata = req_write_data[i*WIDTH +: WIDTH];
                sel_we    = req_write_en[i];
                sel_idx   = PW'(i);
            end
        end
        next_ptr = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_we) begin
                    state_d = WAIT;
                end else begin
                    rdata_d = mem_read_data;
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (mem_done) state_d = RESP;
            end
            RESP: begin
                ptr_d   = next_ptr;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
        end
    end

    assign grant          = grant_q;
    assign req_read_data  = rdata_q;
    // Reset in RESP abandons the access, so the done pulse is suppressed too.
    assign req_done       = (state_q == RESP && !reset) ? grant_q : '0;
    assign mem_addr0      = (state_q == ISSUE) ? sel_addr  : '0;
    assign mem_write_data = (state_q == ISSUE) ? sel_wdata : '0;
    // Gate with reset so a reset landing in ISSUE never commits a write.
    assign mem_write_en   = (state_q == ISSUE) & sel_we & ~reset;

endmodule
